// File: rtl/out_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : out_display_pkg
// Description : Shared types and constants for the out_display block:
//               conversion FSM state enum, digit/sign positions, segment
//               codes and the double-dabble nibble adjust helper.
// Revision    : 1.0 - initial release
// ============================================================================
package out_display_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 10;
    localparam int SIGN_POS   = 10;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Add 3 to every BCD nibble that is >= 5 so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage : out_display_pkg
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decoder
// Description : Combinational BCD digit to active-low seven-segment glyph.
//               Codes above 9 decode to blank.
// Ports       : digit_i [3:0] - BCD digit
//               seg_o   [6:0] - active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decoder
    import out_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0: seg_o = 7'b1000000;
            4'd1: seg_o = 7'b1111001;
            4'd2: seg_o = 7'b0100100;
            4'd3: seg_o = 7'b0110000;
            4'd4: seg_o = 7'b0011001;
            4'd5: seg_o = 7'b0010010;
            4'd6: seg_o = 7'b0000010;
            4'd7: seg_o = 7'b1111000;
            4'd8: seg_o = 7'b0000000;
            4'd9: seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : seven_seg_decoder
`default_nettype wire

// File: rtl/out_display.sv
`default_nettype none
// ============================================================================
// Module      : out_display
// Description : Converts a 32-bit value (unsigned or two's complement) to ten
//               BCD digits with a one-step-per-cycle double-dabble FSM, and
//               multiplexes the held result onto an 11-position active-low
//               seven-segment display (10 digits + sign) with leading-zero
//               blanking.
// Ports       : clock, reset (async, active-high)
//               data_In[31:0], load, signed_Mode   - conversion request
//               busy, done                          - conversion status
//               bcd_Value[39:0], negative           - last completed result
//               seg_Out[6:0], anode_Out[10:0]       - display drive (active-low)
// Revision    : 1.0 - initial release
// ============================================================================
module out_display
    import out_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       data_In,
    input  logic              load,
    input  logic              signed_Mode,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd_Value,
    output logic              negative,
    output logic [6:0]        seg_Out,
    output logic [10:0]       anode_Out
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] C_REFRESH_MAX = CW'(REFRESH_DIV - 1);

    // ------------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [31:0]        mag_q,       mag_d;
    logic [BCD_W-1:0]   shreg_q,     shreg_d;
    logic [5:0]         cnt_q,       cnt_d;
    logic               sign_q,      sign_d;
    logic [BCD_W-1:0]   bcd_value_q, bcd_value_d;
    logic               negative_q,  negative_d;
    logic               done_q,      done_d;

    logic               w_sign_in;
    logic [BCD_W+31:0]  w_shift;

    assign w_sign_in = signed_Mode & data_In[31];
    assign w_shift   = {dabble_adjust(shreg_q), mag_q} << 1;

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        bcd_value_d = bcd_value_q;
        negative_d  = negative_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sign_d  = w_sign_in;
                    mag_d   = w_sign_in ? (-data_In) : data_In;
                    shreg_d = '0;
                    cnt_d   = 6'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {shreg_d, mag_d} = w_shift;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    // 32nd shift: publish the result straight from the shifter
                    bcd_value_d = w_shift[BCD_W+31:32];
                    negative_d  = sign_q;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            bcd_value_q <= '0;
            negative_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            bcd_value_q <= bcd_value_d;
            negative_q  <= negative_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == CONVERT);
    assign done      = done_q;
    assign bcd_Value = bcd_value_q;
    assign negative  = negative_q;

    // ------------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------------
    logic [CW-1:0]      refresh_q, refresh_d;
    logic [3:0]         scan_q,    scan_d;
    logic [6:0]         seg_q,     seg_d;
    logic [10:0]        anode_q,   anode_d;

    logic [NUM_DIGITS-1:0] w_shown;
    logic [3:0]            w_digit;
    logic                  w_digit_shown;
    logic [6:0]            w_glyph;

    // A digit is lit when it is digit 0 or any digit at or above it is nonzero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            if (gi == 0) begin : g_lsd
                assign w_shown[gi] = 1'b1;
            end else begin : g_upper
                assign w_shown[gi] = |bcd_value_q[BCD_W-1:4*gi];
            end
        end
    endgenerate

    always_comb begin
        w_digit       = 4'd0;
        w_digit_shown = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_q == 4'(i)) begin
                w_digit       = bcd_value_q[4*i +: 4];
                w_digit_shown = w_shown[i];
            end
        end
    end

    seven_seg_decoder u_dec (
        .digit_i (w_digit),
        .seg_o   (w_glyph)
    );

    always_comb begin
        refresh_d = refresh_q + CW'(1);
        scan_d    = scan_q;
        if (refresh_q == C_REFRESH_MAX) begin
            refresh_d = '0;
            scan_d    = (scan_q == 4'(SIGN_POS)) ? 4'd0 : scan_q + 4'd1;
        end

        if (scan_q == 4'(SIGN_POS)) begin
            seg_d = negative_q ? SEG_MINUS : SEG_BLANK;
        end else begin
            seg_d = w_digit_shown ? w_glyph : SEG_BLANK;
        end
        anode_d = ~(11'b1 << scan_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_q <= '0;
            scan_q    <= 4'd0;
            seg_q     <= SEG_BLANK;
            anode_q   <= 11'h7FF;
        end else begin
            refresh_q <= refresh_d;
            scan_q    <= scan_d;
            seg_q     <= seg_d;
            anode_q   <= anode_d;
        end
    end

    assign seg_Out   = seg_q;
    assign anode_Out = anode_q;

endmodule : out_display
`default_nettype wire

// File: doc/out_display.md
OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles per display scan position (minimum 1).
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_In  input  32  value produced by the output register bank (its data_Out).
REQ-005 load  input  1  request to capture data_In and start conversion.
REQ-006 signed_Mode  input  1  1 = interpret data_In as two's complement.
REQ-007 busy  output  1  high while conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when a new result is valid.
REQ-009 bcd_Value  output  40  ten BCD digits of the magnitude; digit 0 is in bits [3:0].
REQ-010 negative  output  1  sign of the last completed result.
REQ-011 seg_Out  output  7  active-low segments {g,f,e,d,c,b,a} for the currently selected position.
REQ-012 anode_Out  output  11  active-low one-hot position select; bits 0-9 are digits, bit 10 is the sign.

Function
REQ-013 The conversion FSM SHALL have exactly two states: IDLE and CONVERT.
REQ-014 In IDLE, load=1 SHALL capture the magnitude and sign, clear the BCD shift register, zero a 6-bit cycle counter, and enter CONVERT.
- Sign = signed_Mode & data_In[31].
- Magnitude = -data_In if sign=1, else data_In, 32-bit unsigned; 0x80000000 yields 2147483648.
REQ-015 In CONVERT, each cycle SHALL perform one double-dabble step.
- First, add 3 to every BCD nibble that is >= 5.
- Then shift {bcd, magnitude} left by one.
REQ-016 busy SHALL be high in every cycle the state is CONVERT.
REQ-017 The edge that performs the 32nd shift SHALL register bcd_Value and negative, assert done for exactly one cycle, and return the FSM to IDLE.
- done is therefore high in the cycle following the 32nd edge after the load was sampled.
REQ-018 load asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
- load asserted in the done cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-019 bcd_Value and negative SHALL hold the last completed result until the next completion; they are not cleared by a new load.
REQ-020 A free-running refresh counter SHALL wrap at REFRESH_DIV-1.
- On each wrap, the scan index SHALL advance 0,1,...,10,0.
REQ-021 anode_Out SHALL drive low only the bit equal to the scan index.
REQ-022 seg_Out SHALL show the selected digit's decimal glyph, with leading-zero blanking.
- Digits above the most significant nonzero digit show blank (7'b1111111).
- Digit 0 is always shown.
- Index 10 shows '-' (7'b0111111) when negative=1, otherwise blank.
REQ-023 seg_Out and anode_Out SHALL be registered, lagging the scan index by one cycle.
- They SHALL continue scanning during conversion, using the held bcd_Value.

Reset
REQ-024 While reset=1, all of the following SHALL hold regardless of the clock:
- state=IDLE; busy=0; done=0.
- bcd_Value=0; negative=0.
- Refresh counter=0; scan index=0.
- seg_Out=7'b1111111; anode_Out=11'h7FF.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion; done SHALL NOT pulse for the aborted load.

Structure
REQ-026 A shared package SHALL hold:
- the state enum;
- constants NUM_DIGITS=10 and SIGN_POS=10;
- segment constants SEG_BLANK and SEG_MINUS.
REQ-027 The BCD-to-segment lookup SHALL be a sub-module named seven_seg_decoder, which is purely combinational and outputs active-low codes.

Verification
REQ-028 Unsigned conversion: signed_Mode=0, load with 32'd1234 -> done 32 cycles later, bcd_Value=40'h0000001234, negative=0.
REQ-029 Both modes on all-ones input:
- data_In=32'hFFFFFFFF, signed_Mode=0 -> bcd_Value=40'h4294967295.
- Same data, signed_Mode=1 -> bcd_Value=40'h0000000001, negative=1.
REQ-030 Most-negative value: signed_Mode=1, data_In=32'h80000000 -> bcd_Value=40'h2147483648, negative=1.
REQ-031 Busy and done handshake:
- A second load with a different value at cycle 5 of a conversion is ignored; the result matches the first value.
- A load in the done cycle is accepted, and busy rises on the next edge.
REQ-032 Reset mid-conversion: reset at cycle 10 of a conversion -> all outputs immediately at reset values, and no done pulse occurs.
REQ-033 Display scan: REFRESH_DIV=2, converted value 7, negative=0.
- anode_Out walks 11'h7FE, 11'h7FD, ..., 11'h3FF, changing every 2 cycles.
- seg_Out is 7'b1111000 at position 0 and 7'b1111111 at positions 1-10.
